// File: rtl/conv_window_mac_if.sv
// Column-in / result-out stream bundle for conv_window_mac.
// master = column source + result sink, slave = the convolver.
interface conv_window_mac_if #(
  parameter int DATA_W = 8,
  parameter int KSIZE  = 3
);
  logic                      col_valid;
  logic                      col_ready;
  logic [KSIZE*DATA_W-1:0]   col_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;

  modport master (output col_valid, col_data, out_ready,
                  input  col_ready, out_valid, out_data);
  modport slave  (input  col_valid, col_data, out_ready,
                  output col_ready, out_valid, out_data);
endinterface

// File: rtl/conv_window_mac.sv
// KSIZE x KSIZE sliding-window convolver: builds the window from a column
// stream, runs one MAC per cycle against a stored signed kernel, then
// shifts / ReLUs / saturates each window sum into one output word.
module conv_window_mac #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int KSIZE  = 3,
  parameter int IMG_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [1:0]                         stride,
  input  logic                               relu_en,
  input  logic [4:0]                         out_shift,
  input  logic                               k_wr_en,
  input  logic [$clog2(KSIZE*KSIZE)-1:0]     k_wr_addr,
  input  logic [DATA_W-1:0]                  k_wr_data,
  conv_window_mac_if.slave                   s,
  output logic                               busy,
  output logic                               done
);
  localparam int KN    = KSIZE * KSIZE;
  localparam int KW    = $clog2(KN);
  localparam int CW    = $clog2(KSIZE + 1);
  localparam int RW    = $clog2(KSIZE);
  localparam int OW    = $clog2(IMG_W + 1);
  localparam int NOUT1 = IMG_W - KSIZE + 1;
  localparam int NOUT2 = (IMG_W - KSIZE) / 2 + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_MAC, S_RESULT, S_OUT, S_ADV, S_DONE} state_t;

  state_t                               r_state;
  logic [CW-1:0]                        r_cnt;
  logic [RW-1:0]                        r_mr, r_mc;
  logic [KW-1:0]                        r_ki;
  logic [OW-1:0]                        r_ocnt;
  logic                                 r_stride2, r_relu;
  logic [4:0]                           r_shift;
  logic signed [ACC_W-1:0]              r_acc;
  logic                                 r_col_ready, r_out_valid, r_busy, r_done;
  logic [DATA_W-1:0]                    r_out_data;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] r_win;   // [column][row]
  logic [KN-1:0][DATA_W-1:0]            r_kern;

  logic                                 w_col_hs, w_last_out;
  logic [CW-1:0]                        w_step;
  logic signed [2*DATA_W-1:0]           w_prod;
  logic signed [ACC_W-1:0]              w_prod_ext, w_shr, w_y;

  assign w_col_hs   = s.col_valid & r_col_ready;
  assign w_step     = r_stride2 ? CW'(2) : CW'(1);
  assign w_last_out = (r_ocnt == (r_stride2 ? OW'(NOUT2 - 1) : OW'(NOUT1 - 1)));
  assign w_prod     = $signed(r_win[r_mc][r_mr]) * $signed(r_kern[r_ki]);
  assign w_prod_ext = {{(ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_shr      = r_acc >>> r_shift;

  // Post-processing: floor shift, optional ReLU, clamp to the output range.
  always_comb begin
    w_y = w_shr;
    if (r_relu && w_y < 0) w_y = '0;
    if (w_y > SAT_HI)      w_y = SAT_HI;
    else if (w_y < SAT_LO) w_y = SAT_LO;
  end

  // Window shift register; only moves on a column handshake, so it is
  // naturally frozen during MAC/RESULT/OUT. Contents need no reset.
  always_ff @(posedge clk) begin
    if (w_col_hs) begin
      for (int c = 0; c < KSIZE - 1; c++) r_win[c] <= r_win[c+1];
      r_win[KSIZE-1] <= s.col_data;
    end
  end

  // Kernel store: writable only while idle, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (k_wr_en && r_state == S_IDLE && int'(k_wr_addr) < KN)
      r_kern[k_wr_addr] <= k_wr_data;
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mr        <= '0;
      r_mc        <= '0;
      r_ki        <= '0;
      r_ocnt      <= '0;
      r_stride2   <= 1'b0;
      r_relu      <= 1'b0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_col_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_stride2   <= (stride == 2'd2);
          r_relu      <= relu_en;
          r_shift     <= out_shift;
          r_ocnt      <= '0;
          r_cnt       <= '0;
          r_col_ready <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= S_FILL;
        end
        S_FILL, S_ADV: if (w_col_hs) begin
          if (r_cnt == ((r_state == S_FILL) ? CW'(KSIZE - 1) : w_step - CW'(1))) begin
            r_col_ready <= 1'b0;
            r_acc       <= '0;
            r_ki        <= '0;
            r_mr        <= '0;
            r_mc        <= '0;
            r_state     <= S_MAC;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_ext;
          if (r_ki == KW'(KN - 1)) begin
            r_state <= S_RESULT;
          end else begin
            r_ki <= r_ki + KW'(1);
            if (r_mc == RW'(KSIZE - 1)) begin
              r_mc <= '0;
              r_mr <= r_mr + RW'(1);
            end else begin
              r_mc <= r_mc + RW'(1);
            end
          end
        end
        S_RESULT: begin
          r_out_data  <= w_y[DATA_W-1:0];
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        S_OUT: if (s.out_ready) begin
          r_out_valid <= 1'b0;
          if (w_last_out) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ocnt      <= r_ocnt + OW'(1);
            r_cnt       <= '0;
            r_col_ready <= 1'b1;
            r_state     <= S_ADV;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s.col_ready = r_col_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_data  = r_out_data;
  assign busy        = r_busy;
  assign done        = r_done;
endmodule

// File: tb/tb_conv_window_mac.sv
// Scoreboard bench for conv_window_mac (DATA_W=8, KSIZE=3, IMG_W=8).
module tb_conv_window_mac;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;
  localparam int KSIZE  = 3;
  localparam int IMG_W  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] stride = 2'd0;
  logic       relu_en = 1'b0;
  logic [4:0] out_shift = 5'd0;
  logic       k_wr_en = 1'b0;
  logic [3:0] k_wr_addr = 4'd0;
  logic [7:0] k_wr_data = 8'd0;
  logic       busy, done;

  conv_window_mac_if #(.DATA_W(DATA_W), .KSIZE(KSIZE)) bus ();

  conv_window_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .KSIZE(KSIZE), .IMG_W(IMG_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stride(stride), .relu_en(relu_en),
    .out_shift(out_shift), .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr),
    .k_wr_data(k_wr_data), .s(bus), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int                 checks = 0;
  int                 failures = 0;
  logic signed [7:0]  q[$];
  int                 km[9];
  logic signed [7:0]  pix[8][3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // mode 0: every pixel in column c equals c; otherwise constant v
  task automatic set_pix(input int mode, input int v);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 3; r++)
        pix[c][r] = (mode == 0) ? 8'(c) : 8'(v);
  endtask

  task automatic load_kernel(input int addr, input int v);
    @(negedge clk);
    k_wr_en = 1'b1; k_wr_addr = 4'(addr); k_wr_data = 8'(v);
    @(negedge clk);
    k_wr_en = 1'b0;
    if (addr < 9) km[addr] = v;
  endtask

  task automatic load_all(input int v);
    for (int k = 0; k < 9; k++) load_kernel(k, v);
  endtask

  // Reference model: push expected outputs for one band.
  task automatic push_expected(input logic [1:0] strd, input bit relu, input int sh, output int n);
    int s, sum, y;
    s = (strd == 2'd2) ? 2 : 1;
    n = (IMG_W - KSIZE) / s + 1;
    for (int o = 0; o < n; o++) begin
      sum = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sum += km[r*3+c] * int'(pix[o*s+c][r]);
      y = sum >>> sh;
      if (relu && y < 0) y = 0;
      if (y > 127) y = 127;
      if (y < -128) y = -128;
      q.push_back(8'(y));
    end
  endtask

  task automatic run_band(input string name, input logic [1:0] strd, input bit relu,
                          input int sh, input int exp_cols, input int bp_at,
                          input int stall_at, input bit kwr_busy, input bit start_busy);
    int ncol, nout, ndone, cyc, bp_left, st_left, after, exp_n, ci;
    bit hold, bp_done, st_done;
    logic signed [7:0] held, exp_v;
    q.delete();
    push_expected(strd, relu, sh, exp_n);
    ncol = 0; nout = 0; ndone = 0; bp_left = 0; st_left = 0; after = -1;
    hold = 0; bp_done = 0; st_done = 0; held = '0;
    @(negedge clk);
    stride = strd; relu_en = relu; out_shift = 5'(sh); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // scramble config ports to prove they were latched
    stride = (strd == 2'd2) ? 2'd1 : 2'd2; relu_en = ~relu; out_shift = 5'(sh + 7);
    for (cyc = 0; cyc < 3000 && after != 0; cyc++) begin
      if (stall_at >= 0 && !st_done && ncol == stall_at) begin st_left = 4; st_done = 1; end
      ci = (ncol < 8) ? ncol : 7;
      bus.col_valid = (ncol < 8) && (st_left == 0);
      bus.col_data  = {pix[ci][2], pix[ci][1], pix[ci][0]};
      if (bp_at >= 0 && !bp_done && bus.out_valid && nout == bp_at) begin bp_left = 5; bp_done = 1; end
      bus.out_ready = (bp_left == 0);
      k_wr_en   = kwr_busy && (cyc == 8);
      k_wr_addr = 4'd0;
      k_wr_data = 8'hF9;
      start     = start_busy && (cyc == 12);
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.col_ready !== 1'b0) begin
          failures++;
          $display("FAIL %s hold: valid=%b data=%0d ready=%b want valid=1 data=%0d ready=0",
                   name, bus.out_valid, $signed(bus.out_data), bus.col_ready, held);
        end
      end
      if (st_left > 0) begin
        checks++;
        if (bus.col_ready !== 1'b1) begin
          failures++;
          $display("FAIL %s stall: col_ready=%b want 1", name, bus.col_ready);
        end
      end
      if (bus.col_valid && bus.col_ready) ncol++;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL %s extra output: got %0d want none", name, $signed(bus.out_data));
        end else begin
          exp_v = q.pop_front();
          if (bus.out_data !== exp_v) begin
            failures++;
            $display("FAIL %s out[%0d]: got %0d want %0d", name, nout, $signed(bus.out_data), exp_v);
          end
        end
        nout++; hold = 0;
      end else if (bus.out_valid) begin
        hold = 1; held = bus.out_data;
      end else begin
        hold = 0;
      end
      if (done === 1'b1) ndone++;
      if (ndone > 0 && after < 0) after = 3;
      if (after > 0) after--;
      if (st_left > 0) st_left--;
      if (bp_left > 0) bp_left--;
      @(negedge clk);
    end
    bus.col_valid = 1'b0; bus.out_ready = 1'b0; k_wr_en = 1'b0; start = 1'b0;
    checks++;
    if (after != 0) begin
      failures++;
      $display("FAIL %s timeout: cycles=%0d want done within 3000", name, cyc);
    end
    checks++;
    if (ncol != exp_cols) begin
      failures++;
      $display("FAIL %s columns: got %0d want %0d", name, ncol, exp_cols);
    end
    checks++;
    if (nout != exp_n || ndone != 1) begin
      failures++;
      $display("FAIL %s counts: outputs=%0d done=%0d want outputs=%0d done=1", name, nout, ndone, exp_n);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle busy: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.col_valid = 1'b0; bus.col_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.col_ready, bus.out_valid, busy, done} !== 4'b0 || bus.out_data !== 8'd0) begin
      failures++;
      $display("FAIL reset: rdy/vld/busy/done=%b data=%0d want 0000 data=0",
               {bus.col_ready, bus.out_valid, busy, done}, bus.out_data);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.col_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset idle: busy=%b col_ready=%b want 0 0", busy, bus.col_ready);
    end
  endtask

  task automatic test_stride1();
    set_pix(0, 0);
    run_band("stride1", 2'd1, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_stride2();
    set_pix(0, 0);
    run_band("stride2", 2'd2, 1'b0, 0, 7, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_saturation();
    set_pix(1, 100);
    run_band("sat_pos", 2'd0, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
    run_band("shift3", 2'd0, 1'b0, 3, 8, -1, -1, 1'b0, 1'b0);
    set_pix(1, -100);
    run_band("sat_neg", 2'd0, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_relu();
    load_all(-1);
    set_pix(1, 10);
    run_band("relu_off", 2'd1, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
    run_band("relu_on", 2'd1, 1'b1, 0, 8, -1, -1, 1'b0, 1'b0);
    load_all(1);
  endtask

  task automatic test_backpressure();
    set_pix(0, 0);
    run_band("backpressure", 2'd1, 1'b0, 0, 8, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_kernel_write();
    load_kernel(12, 50);          // out of range: no effect
    set_pix(0, 0);
    run_band("kwr_busy", 2'd2, 1'b0, 0, 7, -1, -1, 1'b1, 1'b0);
    run_band("kwr_after", 2'd1, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_busy();
    set_pix(0, 0);
    run_band("start_busy", 2'd1, 1'b0, 0, 8, -1, -1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n, guard;
    n = 0; guard = 0;
    set_pix(0, 0);
    @(negedge clk);
    stride = 2'd1; relu_en = 1'b0; out_shift = 5'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 3 && guard < 100) begin
      bus.col_valid = 1'b1;
      bus.col_data  = {pix[n][2], pix[n][1], pix[n][0]};
      if (bus.col_ready) n++;
      @(negedge clk);
      guard++;
    end
    bus.col_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: busy=%b want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.col_ready, bus.out_valid, busy, done} !== 4'b0 || bus.out_data !== 8'd0) begin
      failures++;
      $display("FAIL mid_reset: rdy/vld/busy/done=%b data=%0d want 0000 data=0",
               {bus.col_ready, bus.out_valid, busy, done}, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_band("after_reset", 2'd1, 1'b0, 0, 8, -1, -1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    load_all(1);
    test_stride1();
    test_stride2();
    test_saturation();
    test_relu();
    test_backpressure();
    test_kernel_write();
    test_start_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
